iter_mul_unit: RTL and testbench
================================

// Module: iter_mul_unit
// PURPOSE
//  Iterative radix-2 shift-add multiplier that feeds the EX stage for MULT/MULTU.
//  EX holds start_i high and stalls the pipeline until ready_o pulses, then reads
//  result_o into the HI/LO write bundle. Signed mode is handled as magnitude
//  multiply plus a final conditional negate.
// PARAMETERS
//  WIDTH      32  operand width; result is 2*WIDTH
//  ZERO_SKIP  1   1: a zero operand at accept finishes in 1 cycle; 0: always full latency
// PORTS
//  clk         in   1        pipeline clock, rising edge
//  rst         in   1        asynchronous, active-high reset
//  mul_signed  in   1        1 = two's-complement operands (MULT), 0 = unsigned (MULTU)
//  ina         in   WIDTH    multiplicand, sampled only at accept
//  inb         in   WIDTH    multiplier, sampled only at accept
//  start_i     in   1        `MulStart request, level-held by EX while stalled
//  annul_i     in   1        abort the current operation (exception flush)
//  result_o    out  2*WIDTH  product; {HI,LO} for WIDTH=32
//  ready_o     out  1        `MulResultReady, one-cycle pulse
//  busy_o      out  1        high in BUSY or DONE
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, count=0, result_o=0, ready_o=0, busy_o=0.
//  FSM states: IDLE, BUSY, DONE.
//   IDLE: start_i=1 and annul_i=0 => accept. Latch |ina|, |inb| (magnitudes when
//     mul_signed=1, raw values otherwise). Latch neg = mul_signed & (ina[W-1]^inb[W-1]).
//     Clear acc and count. Go to BUSY.
//     With ZERO_SKIP=1 and (ina==0 | inb==0): go directly to DONE with result_o <= 0.
//   BUSY: each edge performs one step.
//     If mplr[0]=1: acc += mcand << count. Then mplr >>= 1, count++.
//     Edge with count==WIDTH-1: write result_o <= neg ? -(final acc) : final acc, go to DONE.
//   DONE: ready_o=1 for exactly this cycle. Next edge returns to IDLE unconditionally.
//     A start_i still high in DONE is not re-accepted. This prevents a double issue
//     of the retiring instruction.
//  Latency: accept edge = E0, ready_o high in the cycle after edge E(WIDTH).
//   For WIDTH=32 this is 33 cycles from accept, or 1 cycle with a zero skip.
//   Minimum gap between two accepts is WIDTH+2 cycles.
//  ready_o and busy_o are registered (decoded from state flops). No combinational
//   path from inputs to outputs.
//  result_o: written only on the transition into DONE. Holds otherwise, including
//   across IDLE and a new BUSY, until the next DONE.
//  ina/inb/mul_signed changes after accept: ignored.
//  start_i dropping during BUSY: ignored; the operation completes.
//  annul_i=1 in BUSY or DONE: next state IDLE. ready_o=0 next cycle. result_o unchanged.
//  annul_i=1 and start_i=1 in IDLE: no accept. annul_i wins.
//  Arithmetic: acc is 2*WIDTH bits. Magnitude of the most negative value is 2^(W-1),
//   representable unsigned. Negate is two's complement on 2*WIDTH bits.
//   No overflow is possible.
// STRUCTURE
//  lib/defines.vh: reuse `MulStart/`MulStop/`MulResultReady/`MulResultNotReady.
//   Add `MulIdle/`MulBusy/`MulDone 2-bit state encodings.
//  No sub-module. Magnitude, negate and step adder stay inline.
//  The counter is $clog2(WIDTH)+1 bits wide.
// TESTING
//  1. MULTU 0xFFFFFFFF*0xFFFFFFFF
//     -> result_o=0xFFFFFFFE_00000001; ready_o pulses 33 cycles after accept.
//  2. MULT 0xFFFFFFFD(-3)*0x00000007
//     -> result_o=0xFFFFFFFF_FFFFFFEB.
//  3. MULT 0x80000000*0x80000000 -> 0x40000000_00000000.
//     MULT 0x80000000*0x00000001 -> 0xFFFFFFFF_80000000.
//  4. ZERO_SKIP=1, MULTU 0x0*0x12345678
//     -> ready_o next cycle, result_o=0. With ZERO_SKIP=0 -> 33 cycles, result_o=0.
//  5. annul_i at cycle 10 of BUSY
//     -> no ready_o, IDLE next cycle, prior result_o kept.
//     A new start 7*6 then completes with 0x2A.
//  6. start_i held high through DONE with new operands -> single ready_o pulse.
//     One IDLE cycle follows, then the new operation is accepted.
//     Async rst mid-BUSY clears all outputs immediately.

Source files
------------

// File: rtl/iter_mul_unit_pkg.sv
// ----------------------------------------------------------------------------
// iter_mul_unit_pkg
//   Shared encodings for the iterative multiplier used by the EX stage.
//   - Handshake levels for the EX <-> multiplier interface (start / ready).
//   - 2-bit FSM state encodings and the typed state enum built from them.
// ----------------------------------------------------------------------------
package iter_mul_unit_pkg;

    // EX-side request levels
    localparam logic MulStart = 1'b1;
    localparam logic MulStop  = 1'b0;

    // Multiplier-side completion levels
    localparam logic MulResultReady    = 1'b1;
    localparam logic MulResultNotReady = 1'b0;

    // State encodings
    localparam logic [1:0] MulIdle = 2'b00;
    localparam logic [1:0] MulBusy = 2'b01;
    localparam logic [1:0] MulDone = 2'b10;

    typedef enum logic [1:0] {
        StIdle = MulIdle,
        StBusy = MulBusy,
        StDone = MulDone
    } mul_state_e;

endpackage : iter_mul_unit_pkg

// File: rtl/iter_mul_unit.sv
// ----------------------------------------------------------------------------
// iter_mul_unit
//   Iterative radix-2 shift-add multiplier for MULT/MULTU. EX holds start_i
//   high and stalls until ready_o pulses, then takes result_o as {HI,LO}.
//   Signed operation is a magnitude multiply followed by a conditional
//   two's-complement negate of the 2*WIDTH-bit product.
//
// Parameters
//   WIDTH      operand width; the product is 2*WIDTH bits
//   ZERO_SKIP  1: a zero operand at accept completes after one cycle
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   mul_signed 1 = two's-complement operands, 0 = unsigned
//   ina, inb   multiplicand / multiplier, sampled only at accept
//   start_i    request, level-held by EX while stalled
//   annul_i    abort the current operation (flush)
//   result_o   product, updated only on entry to DONE
//   ready_o    one-cycle completion pulse (DONE state)
//   busy_o     high in BUSY or DONE
// ----------------------------------------------------------------------------
module iter_mul_unit
    import iter_mul_unit_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter bit          ZERO_SKIP = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mul_signed,
    input  logic [WIDTH-1:0]   ina,
    input  logic [WIDTH-1:0]   inb,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);

    localparam int unsigned ResW = 2 * WIDTH;
    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    mul_state_e        state_q;
    logic [CntW-1:0]   count_q;
    logic [WIDTH-1:0]  mcand_q;
    logic [WIDTH-1:0]  mplr_q;
    logic [ResW-1:0]   acc_q;
    logic              neg_q;
    logic [ResW-1:0]   result_q;

    // Accept-time operand conditioning
    logic              ina_neg;
    logic              inb_neg;
    logic [WIDTH-1:0]  mag_a;
    logic [WIDTH-1:0]  mag_b;
    logic              neg_in;
    logic              zero_in;

    // One shift-add step and the sign-corrected final value
    logic [ResW-1:0]   addend;
    logic [ResW-1:0]   acc_step;
    logic [ResW-1:0]   acc_final;

    always_comb begin
        ina_neg = mul_signed & ina[WIDTH-1];
        inb_neg = mul_signed & inb[WIDTH-1];
        // Magnitude of the most negative value wraps back to itself, which is
        // the correct unsigned 2^(WIDTH-1).
        mag_a   = ina_neg ? (~ina + WIDTH'(1)) : ina;
        mag_b   = inb_neg ? (~inb + WIDTH'(1)) : inb;
        neg_in  = ina_neg ^ inb_neg;
        zero_in = (ina == '0) || (inb == '0);
    end

    always_comb begin
        addend    = mplr_q[0] ? ({{WIDTH{1'b0}}, mcand_q} << count_q) : '0;
        acc_step  = acc_q + addend;
        acc_final = neg_q ? (~acc_step + ResW'(1)) : acc_step;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            count_q  <= '0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // annul_i wins over a simultaneous start request
                    if ((start_i == MulStart) && !annul_i) begin
                        mcand_q <= mag_a;
                        mplr_q  <= mag_b;
                        neg_q   <= neg_in;
                        acc_q   <= '0;
                        count_q <= '0;
                        if (ZERO_SKIP && zero_in) begin
                            result_q <= '0;
                            state_q  <= StDone;
                        end else begin
                            state_q  <= StBusy;
                        end
                    end
                end

                StBusy: begin
                    if (annul_i) begin
                        state_q <= StIdle;
                    end else begin
                        acc_q   <= acc_step;
                        mplr_q  <= mplr_q >> 1;
                        count_q <= count_q + CntW'(1);
                        if (count_q == LastCnt) begin
                            result_q <= acc_final;
                            state_q  <= StDone;
                        end
                    end
                end

                // Always retire to IDLE: a start_i still held for the retiring
                // instruction must not be accepted a second time.
                StDone: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Outputs decode directly from state flops; no input-to-output path.
    assign ready_o  = (state_q == StDone) ? MulResultReady : MulResultNotReady;
    assign busy_o   = (state_q == StBusy) || (state_q == StDone);
    assign result_o = result_q;

endmodule : iter_mul_unit

// File: tb/tb_iter_mul_unit.sv
module tb_iter_mul_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mul_signed;
    logic [31:0] ina;
    logic [31:0] inb;
    logic        start_i;
    logic        start2;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;
    logic [63:0] result2;
    logic        ready2;
    logic        busy2;

    int checks   = 0;
    int failures = 0;

    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    iter_mul_unit #(.WIDTH(32), .ZERO_SKIP(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .mul_signed (mul_signed),
        .ina        (ina),
        .inb        (inb),
        .start_i    (start_i),
        .annul_i    (annul_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .busy_o     (busy_o)
    );

    iter_mul_unit #(.WIDTH(32), .ZERO_SKIP(1'b0)) dut_nz (
        .clk        (clk),
        .rst        (rst),
        .mul_signed (mul_signed),
        .ina        (ina),
        .inb        (inb),
        .start_i    (start2),
        .annul_i    (annul_i),
        .result_o   (result2),
        .ready_o    (ready2),
        .busy_o     (busy2)
    );

    function automatic logic [63:0] model(input logic s, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (s) begin
            sa = $signed({{32{a[31]}}, a});
            sb = $signed({{32{b[31]}}, b});
            return sa * sb;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for ready_o, then checks latency, busy_o and the popped result.
    task automatic wait_ready(input int exp_lat, input string tag);
        int          lat;
        bit          got;
        logic [63:0] exp;
        lat = 0;
        got = 1'b0;
        for (int i = 1; i <= 100 && !got; i++) begin
            @(negedge clk);
            if (ready_o) begin
                got = 1'b1;
                lat = i;
            end
        end
        check({tag, "_ready_seen"}, 64'(got), 64'd1);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy_in_done"}, 64'(busy_o), 64'd1);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_nonempty"}, 64'd0, 64'd1);
        end else begin
            exp = sb_q.pop_front();
            check({tag, "_result"}, result_o, exp);
        end
    endtask

    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input bit hold, input string tag);
        @(negedge clk);
        check({tag, "_idle_ready"}, 64'(ready_o), 64'd0);
        check({tag, "_idle_busy"}, 64'(busy_o), 64'd0);
        mul_signed = s;
        ina        = a;
        inb        = b;
        start_i    = 1'b1;
        sb_q.push_back(model(s, a, b));
        @(posedge clk);
        #1;
        if (!hold) start_i = 1'b0;
        // Operand changes after accept must be ignored.
        ina        = ~a;
        inb        = ~b;
        mul_signed = ~s;
        wait_ready(exp_lat, tag);
    endtask

    initial begin
        logic [63:0] prior;
        int          lat2;
        int          spurious;
        rst        = 1'b1;
        mul_signed = 1'b0;
        ina        = '0;
        inb        = '0;
        start_i    = 1'b0;
        start2     = 1'b0;
        annul_i    = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_result", result_o, 64'd0);
        check("rst_ready", 64'(ready_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        rst = 1'b0;

        // 1: unsigned full-scale
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b0, "multu_ff");
        check("multu_ff_const", result_o, 64'hFFFF_FFFE_0000_0001);
        @(negedge clk);
        check("multu_ff_single_pulse", 64'(ready_o), 64'd0);

        // 2/3: signed cases
        run_op(1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 33, 1'b0, "mult_m3x7");
        check("mult_m3x7_const", result_o, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 33, 1'b0, "mult_min_min");
        check("mult_min_min_const", result_o, 64'h4000_0000_0000_0000);
        run_op(1'b1, 32'h8000_0000, 32'h0000_0001, 33, 1'b0, "mult_min_1");
        check("mult_min_1_const", result_o, 64'hFFFF_FFFF_8000_0000);

        // 4: zero skip on the main instance
        run_op(1'b0, 32'h0, 32'h1234_5678, 1, 1'b0, "zskip_a");
        run_op(1'b1, 32'hDEAD_BEEF, 32'h0, 1, 1'b0, "zskip_b");

        // 4: no zero skip on the second instance
        @(negedge clk);
        mul_signed = 1'b0;
        ina        = 32'h0;
        inb        = 32'h1234_5678;
        start2     = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        lat2   = 0;
        for (int i = 1; i <= 100 && lat2 == 0; i++) begin
            @(negedge clk);
            if (ready2) lat2 = i;
        end
        check("noskip_latency", 64'(lat2), 64'd33);
        check("noskip_result", result2, 64'd0);

        // Mixed random operands
        for (int k = 0; k < 6; k++) begin
            run_op(1'(k & 1), $urandom, $urandom, 33, 1'b0, "rand");
        end

        // 5: annul at cycle 10 of BUSY
        prior = result_o;
        @(negedge clk);
        mul_signed = 1'b0;
        ina        = 32'h1234_5678;
        inb        = 32'h0000_0F0F;
        start_i    = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        @(negedge clk);
        check("annul_ready", 64'(ready_o), 64'd0);
        check("annul_busy", 64'(busy_o), 64'd0);
        check("annul_result_kept", result_o, prior);
        spurious = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready_o) spurious++;
        end
        check("annul_no_ready", 64'(spurious), 64'd0);
        run_op(1'b0, 32'd7, 32'd6, 33, 1'b0, "after_annul");
        check("after_annul_const", result_o, 64'h2A);

        // 6: start held through DONE -> one pulse, one IDLE cycle, then re-accept
        run_op(1'b0, 32'd3, 32'd5, 33, 1'b1, "held");
        mul_signed = 1'b0;
        ina        = 32'd9;
        inb        = 32'd11;
        sb_q.push_back(model(1'b0, 32'd9, 32'd11));
        @(negedge clk);
        check("held_no_reissue_ready", 64'(ready_o), 64'd0);
        check("held_idle_busy", 64'(busy_o), 64'd0);
        wait_ready(33, "held_next");
        start_i = 1'b0;

        // 6: async reset mid-BUSY
        @(negedge clk);
        ina     = 32'd5;
        inb     = 32'd5;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst_busy", 64'(busy_o), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_result", result_o, 64'd0);
        check("async_rst_ready", 64'(ready_o), 64'd0);
        check("async_rst_busy", 64'(busy_o), 64'd0);
        #3;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 64'(busy_o), 64'd0);

        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_iter_mul_unit
